// File: rtl/cache_pkg.sv
// Shared types and width helpers for the data-cache flush sequencer.
package cache_pkg;

   // Walk modes; the raw encoding 2'b11 is folded onto FL_FLUSH by decode_mode.
   typedef enum logic [1:0] {
      FL_FLUSH = 2'b00,
      FL_CLEAN = 2'b01,
      FL_INVAL = 2'b10
   } fl_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_TAG,
      ST_CHK,
      ST_WB_RD,
      ST_WB_SEND,
      ST_UPD,
      ST_NEXT,
      ST_DONE
   } fl_state_e;

   localparam int LINES_WB_W = 16;

   // Index width that never collapses to zero (a direct-mapped cache still needs a way bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic fl_mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         2'b01:   return FL_CLEAN;
         2'b10:   return FL_INVAL;
         default: return FL_FLUSH;
      endcase
   endfunction

endpackage

// File: rtl/cache_flush_ctrl_if.sv
// Tag/data array and write-back memory port of the flush sequencer.
// Handshake: mem_req is valid; a word transfers on any cycle where mem_req and
// mem_gnt are both high; mem_addr/mem_wdata/mem_last stay stable while mem_req
// waits for mem_gnt, and mem_req never depends combinationally on mem_gnt.
interface cache_flush_ctrl_if #(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32
);
   import cache_pkg::*;

   localparam int SET_W  = $clog2(SETS);
   localparam int WAY_W  = idx_w(WAYS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int TAG_W  = ADDR_W - SET_W - WORD_W - BYTE_W;

   logic [SET_W-1:0]  arr_set;
   logic [WAY_W-1:0]  arr_way;
   logic              ta_rd;
   logic              ta_valid;
   logic              ta_dirty;
   logic [TAG_W-1:0]  ta_tag;
   logic              ta_wr;
   logic              ta_wr_valid;
   logic              ta_wr_dirty;
   logic              da_rd;
   logic [WORD_W-1:0] da_word;
   logic [DATA_W-1:0] da_rdata;
   logic              mem_req;
   logic              mem_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_last;

   modport master (
      output arr_set, arr_way, ta_rd, ta_wr, ta_wr_valid, ta_wr_dirty,
      output da_rd, da_word, mem_req, mem_addr, mem_wdata, mem_last,
      input  ta_valid, ta_dirty, ta_tag, da_rdata, mem_gnt
   );

   modport slave (
      input  arr_set, arr_way, ta_rd, ta_wr, ta_wr_valid, ta_wr_dirty,
      input  da_rd, da_word, mem_req, mem_addr, mem_wdata, mem_last,
      output ta_valid, ta_dirty, ta_tag, da_rdata, mem_gnt
   );

endinterface

// File: rtl/cache_walk_cnt.sv
// Set/way/word position counters for the flush walk, with terminal flags.
module cache_walk_cnt
   import cache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8,
   parameter int SET_W      = $clog2(SETS),
   parameter int WAY_W      = idx_w(WAYS),
   parameter int WORD_W     = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              way_step,
   input  logic              word_step,
   output logic [SET_W-1:0]  set_idx,
   output logic [WAY_W-1:0]  way_idx,
   output logic [WORD_W-1:0] word_idx,
   output logic              last_set,
   output logic              last_way,
   output logic              last_word
);

   assign last_set  = (set_idx == SET_W'(SETS - 1));
   assign last_way  = (way_idx == WAY_W'(WAYS - 1));
   assign last_word = (word_idx == WORD_W'(LINE_WORDS - 1));

   // Way steps first and carries into set; word wraps back to 0 after the last word of a line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_idx  <= '0;
         way_idx  <= '0;
         word_idx <= '0;
      end else if (clr) begin
         set_idx  <= '0;
         way_idx  <= '0;
         word_idx <= '0;
      end else begin
         if (way_step) begin
            if (last_way) begin
               way_idx <= '0;
               set_idx <= last_set ? '0 : set_idx + 1'b1;
            end else begin
               way_idx <= way_idx + 1'b1;
            end
         end
         if (word_step) begin
            word_idx <= last_word ? '0 : word_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_flush_ctrl.sv
// Flush / clean / invalidate sequencer: walks every set and way, writes dirty
// lines back word by word, then rewrites the tag state of each touched line.
module cache_flush_ctrl
   import cache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fl_start,
   input  logic [1:0]            fl_mode,
   output logic                  fl_busy,
   output logic                  fl_complete,
   output logic [LINES_WB_W-1:0] fl_lines_wb,
   output fl_state_e             dbg_state,
   cache_flush_ctrl_if.master    bus
);

   localparam int SET_W  = $clog2(SETS);
   localparam int WAY_W  = idx_w(WAYS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int TAG_W  = ADDR_W - SET_W - WORD_W - BYTE_W;
   localparam int OFF_W  = WORD_W + BYTE_W;

   fl_state_e         state_q, state_d;
   fl_mode_e          mode_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rd_pend_q;

   logic [SET_W-1:0]  set_idx;
   logic [WAY_W-1:0]  way_idx;
   logic [WORD_W-1:0] word_idx;
   logic              last_set, last_way, last_word;

   logic              cnt_clr, way_step, word_step;
   logic              start_ok, tag_ld, wb_done, walk_end;

   cache_walk_cnt #(
      .SETS       (SETS),
      .WAYS       (WAYS),
      .LINE_WORDS (LINE_WORDS)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .way_step  (way_step),
      .word_step (word_step),
      .set_idx   (set_idx),
      .way_idx   (way_idx),
      .word_idx  (word_idx),
      .last_set  (last_set),
      .last_way  (last_way),
      .last_word (last_word)
   );

   assign bus.arr_set     = set_idx;
   assign bus.arr_way     = way_idx;
   assign bus.da_word     = word_idx;
   assign bus.ta_wr_dirty = 1'b0;
   assign bus.mem_last    = bus.mem_req & last_word;
   assign bus.mem_addr    = (ADDR_W'(tag_q) << (SET_W + OFF_W))
                          | (ADDR_W'(set_idx) << OFF_W)
                          | (ADDR_W'(word_idx) << BYTE_W);
   // The array presents da_rdata only in the cycle after da_rd; forward it then,
   // and replay the captured copy for as long as the memory stalls.
   assign bus.mem_wdata   = rd_pend_q ? bus.da_rdata : wdata_q;
   assign dbg_state       = state_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and Moore strobes; mem_req depends on state only.
   always_comb begin
      state_d         = state_q;
      cnt_clr         = 1'b0;
      way_step        = 1'b0;
      word_step       = 1'b0;
      start_ok        = 1'b0;
      tag_ld          = 1'b0;
      wb_done         = 1'b0;
      walk_end        = 1'b0;
      bus.ta_rd       = 1'b0;
      bus.ta_wr       = 1'b0;
      bus.ta_wr_valid = 1'b0;
      bus.da_rd       = 1'b0;
      bus.mem_req     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (fl_start) begin
               state_d  = ST_RD_TAG;
               cnt_clr  = 1'b1;
               start_ok = 1'b1;
            end
         end
         ST_RD_TAG: begin
            bus.ta_rd = 1'b1;
            state_d   = ST_CHK;
         end
         ST_CHK: begin
            if (!bus.ta_valid)             state_d = ST_NEXT;
            else if (mode_q == FL_INVAL)   state_d = ST_UPD;
            else if (bus.ta_dirty) begin
               state_d = ST_WB_RD;
               tag_ld  = 1'b1;
            end
            else if (mode_q == FL_FLUSH)   state_d = ST_UPD;
            else                           state_d = ST_NEXT;
         end
         ST_WB_RD: begin
            bus.da_rd = 1'b1;
            state_d   = ST_WB_SEND;
         end
         ST_WB_SEND: begin
            bus.mem_req = 1'b1;
            if (bus.mem_gnt) begin
               word_step = 1'b1;
               if (last_word) begin
                  wb_done = 1'b1;
                  state_d = ST_UPD;
               end else begin
                  state_d = ST_WB_RD;
               end
            end
         end
         ST_UPD: begin
            bus.ta_wr       = 1'b1;
            bus.ta_wr_valid = (mode_q == FL_CLEAN);
            state_d         = ST_NEXT;
         end
         ST_NEXT: begin
            way_step = 1'b1;
            if (last_way && last_set) begin
               walk_end = 1'b1;
               state_d  = ST_DONE;
            end else begin
               state_d  = ST_RD_TAG;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Walk bookkeeping: latched mode/tag, status flags, write-back count, data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= FL_FLUSH;
         tag_q       <= '0;
         fl_busy     <= 1'b0;
         fl_complete <= 1'b0;
         fl_lines_wb <= '0;
         rd_pend_q   <= 1'b0;
         wdata_q     <= '0;
      end else begin
         rd_pend_q <= bus.da_rd;
         if (rd_pend_q) wdata_q <= bus.da_rdata;
         if (tag_ld)    tag_q   <= bus.ta_tag;
         if (start_ok) begin
            mode_q      <= decode_mode(fl_mode);
            fl_busy     <= 1'b1;
            fl_complete <= 1'b0;
            fl_lines_wb <= '0;
         end
         if (wb_done && (fl_lines_wb != {LINES_WB_W{1'b1}})) begin
            fl_lines_wb <= fl_lines_wb + 1'b1;
         end
         if (walk_end) begin
            fl_busy     <= 1'b0;
            fl_complete <= 1'b1;
         end
      end
   end

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Parametrised flush/clean/invalidate sequencer for the write-back RISC-V data cache inside rv_cache_sint_top.
- Walks every set and way, writes dirty lines back to memory word by word over a valid/ready port, then updates tag state.
- Raises fl_complete when the walk ends. This generalises the fixed single-mode flush-complete flag into a multi-mode, geometry-parametrised engine with a write-back counter.

Parameters:
- SETS, 64, number of sets (power of 2, >=2)
- WAYS, 4, associativity (power of 2, >=1)
- LINE_WORDS, 8, words per line (power of 2, >=2)
- DATA_W, 32, word width (multiple of 8)
- ADDR_W, 32, byte address width
- TAG_W, ADDR_W-$clog2(SETS)-$clog2(LINE_WORDS)-$clog2(DATA_W/8), tag width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- fl_start  in  1  start request, sampled only in IDLE/DONE
- fl_mode  in  2  00 flush (WB+invalidate), 01 clean (WB, clear dirty), 10 invalidate only, 11 treated as 00; latched at start
- fl_busy  out  1  walk in progress
- fl_complete  out  1  walk finished; level, held until next accepted start
- fl_lines_wb  out  16  count of lines written back in the last/current walk, saturating at 16'hFFFF
- arr_set  out  $clog2(SETS)  set index to tag/data arrays
- arr_way  out  max(1,$clog2(WAYS))  way index
- ta_rd  out  1  tag read strobe; ta_* valid next cycle
- ta_valid  in  1  line valid
- ta_dirty  in  1  line dirty
- ta_tag  in  TAG_W  line tag
- ta_wr  out  1  tag state write strobe (one cycle)
- ta_wr_valid  out  1  new valid bit
- ta_wr_dirty  out  1  new dirty bit
- da_rd  out  1  data read strobe; da_rdata valid next cycle
- da_word  out  $clog2(LINE_WORDS)  word index within line
- da_rdata  in  DATA_W  data word
- mem_req  out  1  write-back request (valid)
- mem_gnt  in  1  memory accept (ready)
- mem_addr  out  ADDR_W  byte address {tag,set,word,0s}
- mem_wdata  out  DATA_W  write data
- mem_last  out  1  high on last word of line

Behaviour:
- Reset (async): state IDLE; all outputs 0; set/way/word counters 0; fl_lines_wb 0.
- FSM states: IDLE, RD_TAG, CHK, WB_RD, WB_SEND, UPD, NEXT, DONE.
- IDLE/DONE + fl_start=1 -> RD_TAG.
  - Latch mode; clear counters and fl_lines_wb; fl_complete<=0; fl_busy<=1.
- RD_TAG: ta_rd=1 for exactly one cycle -> CHK.
- CHK: ta_* sampled.
  - valid=0 -> NEXT.
  - mode invalidate -> UPD.
  - dirty=1 and mode flush/clean -> WB_RD (latch tag).
  - Otherwise -> UPD if mode flush, else NEXT.
- WB_RD: da_rd=1 with da_word -> WB_SEND.
- WB_SEND:
  - mem_req=1; mem_addr, mem_wdata (registered from da_rdata) and mem_last held stable until mem_gnt.
  - On mem_gnt: if last word -> UPD, incrementing fl_lines_wb; else word++ -> WB_RD.
  - No combinational path from mem_gnt to mem_req.
- UPD: ta_wr=1 for one cycle -> NEXT.
  - flush/invalidate: valid=0, dirty=0.
  - clean: valid=1, dirty=0.
- NEXT: way++. On way wrap, set++. On set wrap with last way -> DONE, else -> RD_TAG.
- DONE: fl_busy=0, fl_complete=1, held; accepts new start.
- fl_start while busy: ignored. fl_mode changes mid-walk: ignored.
- Minimum walk latency with all lines invalid: 3*SETS*WAYS+1 cycles from start to fl_complete.
- Dirty line with mem_gnt always high: 2*LINE_WORDS+1 extra cycles per line.
- Reset mid-walk: immediate return to IDLE. The partially written line is not completed; fl_complete=0.
- arr_set/arr_way/da_word are registered counters; they change only in NEXT/WB_SEND.

Decomposition:
- Shared package cache_pkg:
  - fl_mode_e enum (FL_FLUSH, FL_CLEAN, FL_INVAL)
  - fl_state_e enum
  - localparam helpers for index/offset widths
- One sub-module, cache_walk_cnt: set/way/word counter with wrap and terminal flags.

Test Plan (SETS=4, WAYS=2, LINE_WORDS=4, DATA_W=32, ADDR_W=32):
- All lines invalid, start flush -> fl_complete at cycle 25, no mem_req, no ta_wr, fl_lines_wb=0.
- Set 2 way 1 valid+dirty tag 0x1234, mem_gnt=1, mode flush -> 4 writes at mem_addr 0x00048D20, 0x00048D24, 0x00048D28, 0x00048D2C (the last with mem_last=1), then ta_wr with valid=0,dirty=0; fl_lines_wb=1.
- Same line, mode clean, mem_gnt low 3 cycles per word -> address/data stable while stalled; ta_wr valid=1,dirty=0.
- All 8 lines valid+dirty, mode invalidate -> no mem_req, 8 ta_wr pulses with valid=0, fl_lines_wb=0.
- rst asserted during the 2nd word of a write-back -> outputs 0 immediately, fl_complete=0; a new flush restarts from set 0 way 0.
- fl_start pulsed while busy, and fl_mode=11 -> extra start ignored; mode 11 behaves exactly as flush.
